// File: rtl/vld_mux_pkg.sv
// Shared constants and bit-vector helpers for the valid-qualified mux family.
// Helpers work on a fixed maximum width; callers zero-extend their narrower vectors.
package vld_mux_pkg;

  localparam int VLD_MUX_MODE_PAR  = 0;
  localparam int VLD_MUX_MODE_PRIO = 1;
  localparam int VLD_MUX_MAX_W     = 64;

  typedef logic [VLD_MUX_MAX_W-1:0] vld_mux_vec_t;

  // Isolate the lowest set bit (two's-complement trick x & -x).
  function automatic vld_mux_vec_t lowest_set(input vld_mux_vec_t x);
    return x & (~x + vld_mux_vec_t'(1));
  endfunction

  // True when more than one bit of x is set.
  function automatic logic is_multi(input vld_mux_vec_t x);
    return (x & (x - vld_mux_vec_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/vld_muxn_core.sv
// Combinational N-way selector: AND-OR of selected channels (MODE 0) or
// lowest-index winner (MODE 1). Unselected channel data is always masked.
module vld_muxn_core
  import vld_mux_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NCH  = 5,
  parameter int MODE = VLD_MUX_MODE_PAR
) (
  input  logic [NCH-1:0]    sel,
  input  logic [NCH*DW-1:0] data,
  output logic [DW-1:0]     out,
  output logic [NCH-1:0]    grant,
  output logic              multi
);

  vld_mux_vec_t sel_ext;
  vld_mux_vec_t low_ext;
  logic         unused_low_bits;

  // NCH must not exceed VLD_MUX_MAX_W; the extension below relies on it.
  always_comb begin
    sel_ext            = '0;
    sel_ext[NCH-1:0]   = sel;
  end

  assign low_ext         = lowest_set(sel_ext);
  assign unused_low_bits = ^low_ext;
  assign multi           = is_multi(sel_ext);

  always_comb begin
    grant = sel;
    if (MODE == VLD_MUX_MODE_PRIO) begin
      grant = low_ext[NCH-1:0];
    end
  end

  // With a one-hot grant the AND-OR collapses to a plain select.
  always_comb begin
    out = '0;
    for (int k = 0; k < NCH; k++) begin
      out = out | ({DW{grant[k]}} & data[k*DW +: DW]);
    end
  end

endmodule

// File: rtl/vld_muxn_reg.sv
// Valid-qualified N-channel mux with a single registered output stage,
// output valid/ready back-pressure and a sticky multi-select error flag.
module vld_muxn_reg
  import vld_mux_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NCH  = 5,
  parameter int MODE = VLD_MUX_MODE_PAR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    sel_i,
  input  logic [NCH*DW-1:0] in_i,
  output logic              in_rdy_o,
  output logic [DW-1:0]     out_o,
  output logic [NCH-1:0]    grant_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              err_o,
  input  logic              err_clr_i
);

  // Handshake: a transfer out happens on a cycle with vld_o & rdy_i; the
  // stage accepts a new item on |sel_i & in_rdy_o, and in_rdy_o is high
  // whenever the stage is empty or is being drained this same cycle.
  // Upstream holds sel_i/in_i stable until it observes in_rdy_o high.

  logic [DW-1:0]  core_out;
  logic [NCH-1:0] core_grant;
  logic           core_multi;
  logic           acc;
  logic           err_set;

  vld_muxn_core #(
    .DW  (DW),
    .NCH (NCH),
    .MODE(MODE)
  ) u_core (
    .sel  (sel_i),
    .data (in_i),
    .out  (core_out),
    .grant(core_grant),
    .multi(core_multi)
  );

  assign in_rdy_o = ~vld_o | rdy_i;
  assign acc      = (|sel_i) & in_rdy_o;
  assign err_set  = (MODE == VLD_MUX_MODE_PAR) & acc & core_multi;

  // out_o/grant_o keep their last captured value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_o   <= '0;
      grant_o <= '0;
      vld_o   <= 1'b0;
    end else if (acc) begin
      out_o   <= core_out;
      grant_o <= core_grant;
      vld_o   <= 1'b1;
    end else if (vld_o && rdy_i) begin
      vld_o   <= 1'b0;
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vld_muxn_reg.sv
// Bench for vld_muxn_reg: one parallel-mode and one priority-mode instance
// share the same stimulus and are compared against a per-cycle reference model.
module tb_vld_muxn_reg;
  import vld_mux_pkg::*;

  localparam int DW  = 8;
  localparam int NCH = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0]    sel;
  logic [NCH*DW-1:0] in_flat;
  logic              rdy;
  logic              clr;

  logic              in_rdy0, in_rdy1;
  logic [DW-1:0]     out0, out1;
  logic [NCH-1:0]    grant0, grant1;
  logic              vld0, vld1;
  logic              err0, err1;

  vld_muxn_reg #(.DW(DW), .NCH(NCH), .MODE(VLD_MUX_MODE_PAR)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel_i(sel), .in_i(in_flat), .in_rdy_o(in_rdy0),
    .out_o(out0), .grant_o(grant0), .vld_o(vld0), .rdy_i(rdy),
    .err_o(err0), .err_clr_i(clr)
  );

  vld_muxn_reg #(.DW(DW), .NCH(NCH), .MODE(VLD_MUX_MODE_PRIO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel_i(sel), .in_i(in_flat), .in_rdy_o(in_rdy1),
    .out_o(out1), .grant_o(grant1), .vld_o(vld1), .rdy_i(rdy),
    .err_o(err1), .err_clr_i(clr)
  );

  // ---------------- reference model ----------------
  logic          m_vld;
  logic [DW-1:0] m_out0, m_out1;
  logic [NCH-1:0] m_g0, m_g1;
  logic          m_err;
  logic          last_in_rdy;
  logic [DW-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] chan(input logic [NCH*DW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction

  function automatic logic [NCH*DW-1:0] pack5(input logic [DW-1:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_out0 = '0;
    m_out1 = '0;
    m_g0   = '0;
    m_g1   = '0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  // One clock of behaviour, computed from the selection rules directly.
  task automatic model_step();
    logic acc_m;
    int   win;
    acc_m = (sel != '0) && (!m_vld || rdy);
    if (acc_m) begin
      m_out0 = '0;
      for (int k = 0; k < NCH; k++)
        if (sel[k]) m_out0 = m_out0 | chan(in_flat, k);
      m_g0 = sel;
      win = -1;
      for (int k = NCH - 1; k >= 0; k--)
        if (sel[k]) win = k;
      m_out1 = chan(in_flat, win);
      m_g1   = '0;
      m_g1[win] = 1'b1;
      m_vld  = 1'b1;
      exp_q.push_back(m_out0);
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    if (acc_m && ($countones(sel) > 1)) m_err = 1'b1;
    else if (clr)                       m_err = 1'b0;
  endtask

  task automatic compare_all();
    check("vld0",   32'(vld0),   32'(m_vld));
    check("vld1",   32'(vld1),   32'(m_vld));
    check("out0",   32'(out0),   32'(m_out0));
    check("out1",   32'(out1),   32'(m_out1));
    check("grant0", 32'(grant0), 32'(m_g0));
    check("grant1", 32'(grant1), 32'(m_g1));
    check("err0",   32'(err0),   32'(m_err));
    check("err1",   32'(err1),   32'(0));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NCH-1:0] s, input logic [NCH*DW-1:0] d,
                       input logic r, input logic c);
    logic [DW-1:0] e;
    @(negedge clk);
    sel = s; in_flat = d; rdy = r; clr = c;
    #1;
    last_in_rdy = !m_vld || r;
    check("in_rdy0", 32'(in_rdy0), 32'(last_in_rdy));
    check("in_rdy1", 32'(in_rdy1), 32'(last_in_rdy));
    if (m_vld && r) begin
      if (exp_q.size() == 0) begin
        check("xfer_q_empty", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("xfer", 32'(out0), 32'(e));
      end
    end
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NCH-1:0]    rs;
    logic [NCH*DW-1:0] rd;
    logic              rr;
    int                pick;

    rst_n = 1'b0; sel = '0; in_flat = '0; rdy = 1'b0; clr = 1'b0;
    last_in_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single parallel-mode transfer, then empty
    drive(5'b00100, pack5(8'h00, 8'h00, 8'hA5, 8'h00, 8'h00), 1'b1, 1'b0);
    check("t1_out", 32'(out0), 32'h A5);
    check("t1_grant", 32'(grant0), 32'b00100);
    drive(5'b00000, '0, 1'b1, 1'b0);
    check("t1_drain", 32'(vld0), 32'(0));

    // back-pressure
    drive(5'b00010, pack5(8'h00, 8'h3C, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
    repeat (4) begin
      drive(5'b00001, pack5(8'h11, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
      check("t2_hold", 32'(out0), 32'h3C);
    end
    drive(5'b00001, pack5(8'h11, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
    check("t2_load", 32'(out0), 32'h11);

    // streaming through all channels
    for (int k = 0; k < NCH; k++) begin
      drive(5'(1 << k), 40'({$urandom(), $urandom()}), 1'b1, 1'b0);
      check("t3_grant", 32'(grant0), 32'(1 << k));
    end

    // multi-hot: error set, set-beats-clear, plain clear; priority winner
    drive(5'b10010, pack5(8'h00, 8'h0F, 8'h00, 8'h00, 8'hF0), 1'b1, 1'b0);
    check("t4_out", 32'(out0), 32'hFF);
    check("t4_err", 32'(err0), 32'(1));
    drive(5'b00110, 40'({$urandom(), $urandom()}), 1'b1, 1'b1);
    check("t4_err_hold", 32'(err0), 32'(1));
    drive(5'b00000, '0, 1'b1, 1'b1);
    check("t4_err_clr", 32'(err0), 32'(0));
    drive(5'b11010, pack5(8'h00, 8'h22, 8'h00, 8'h44, 8'h00), 1'b1, 1'b0);
    check("t5_out1", 32'(out1), 32'h22);
    check("t5_grant1", 32'(grant1), 32'b00010);

    // randomized traffic, honouring the upstream hold rule
    rs = '0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(rs != '0 && !last_in_rdy)) begin
        pick = $urandom_range(0, 9);
        if (pick < 2)      rs = '0;
        else if (pick < 8) rs = 5'(1 << $urandom_range(0, NCH - 1));
        else               rs = 5'($urandom_range(1, 31));
        rd = 40'({$urandom(), $urandom()});
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(rs, rd, rr, ($urandom_range(0, 7) == 0));
    end

    // async reset in the middle of a stall
    drive(5'b00011, pack5(8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
    @(negedge clk);
    sel = '0; rdy = 1'b0; clr = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
